// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: RV32I opcode encodings and controller state.
// No logic, no latency.
// No flow control.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

endpackage

package control;

    // RUN: pipeline advancing normally; WAIT: frozen on an outstanding cache access.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    localparam logic [0:0] HZ_RUN  = 1'b0;
    localparam logic [0:0] HZ_WAIT = 1'b1;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running event counter, wraps modulo 2^WIDTH.
// Count visible one cycle after the inc pulse.
// No backpressure; every inc cycle is counted.
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Synchronous active-low clear, otherwise count qualifying cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline load/flush/redirect control with cache-miss freeze, load-use bubble and mispredict recovery.
// Controls are combinational from current inputs; done flags and counters update next edge.
// Whole pipeline freezes until both the fetch and the memory access have completed.
module pipeline_hazard_ctrl
    import rv32i_types::*;
    import control::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [6:0]           ex_opcode,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_br_resolved,
    input  logic                 ex_br_taken,
    input  logic                 ex_prediction,
    input  logic                 imem_resp,
    input  logic                 dmem_pending,
    input  logic                 dmem_resp,
    output logic                 imem_req_en,
    output logic                 dmem_hold,
    output logic                 pc_load,
    output logic                 pc_redirect,
    output logic                 if_id_load,
    output logic                 if_id_flush,
    output logic                 id_exe_load,
    output logic                 id_exe_flush,
    output logic                 exe_mem_load,
    output logic                 mem_wb_load,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    logic [0:0] state;
    logic       f_done;
    logic       d_done;
    logic       f_ok;
    logic       d_ok;
    logic       advance;
    logic       mispred;
    logic       lu_haz;

    assign f_ok    = imem_resp | f_done;
    assign d_ok    = ~dmem_pending | dmem_resp | d_done;
    assign advance = f_ok & d_ok;
    assign mispred = ex_br_resolved & (ex_br_taken != ex_prediction);
    assign lu_haz  = (ex_opcode == op_load) && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Reset overrides the flags so the fetch stage re-requests immediately.
    assign imem_req_en = ~rst | ~f_done;
    assign dmem_hold   = rst & d_done;

    // State and sticky completion flags. A response arriving on the first frozen
    // cycle (still in RUN) must also be captured, otherwise it would be lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= HZ_RUN;
            f_done <= 1'b0;
            d_done <= 1'b0;
        end else if (advance) begin
            state  <= HZ_RUN;
            f_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            state <= HZ_WAIT;
            if (state == HZ_WAIT) begin
                f_done <= f_done | imem_resp;
                d_done <= d_done | dmem_resp;
            end else begin
                f_done <= imem_resp;
                d_done <= dmem_resp;
            end
        end
    end

    // Pipeline register controls; mispredict outranks load-use, freeze outranks both.
    always_comb begin
        pc_load      = 1'b0;
        pc_redirect  = 1'b0;
        if_id_load   = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_load  = 1'b0;
        id_exe_flush = 1'b0;
        exe_mem_load = 1'b0;
        mem_wb_load  = 1'b0;
        if (rst && advance) begin
            pc_load      = 1'b1;
            if_id_load   = 1'b1;
            id_exe_load  = 1'b1;
            exe_mem_load = 1'b1;
            mem_wb_load  = 1'b1;
            if (mispred) begin
                pc_redirect  = 1'b1;
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (lu_haz) begin
                pc_load      = 1'b0;
                if_id_load   = 1'b0;
                id_exe_flush = 1'b1;
            end
        end
    end

    perf_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~advance),
        .count (stall_cnt)
    );

    perf_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (advance & ~mispred & lu_haz),
        .count (bubble_cnt)
    );

    perf_counter #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (advance & mispred),
        .count (mispred_cnt)
    );

endmodule
